// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: demand-actuated multi-phase intersection controller.
// Serves one phase at a time through green -> yellow -> all-red and skips
// phases that have no latched demand. When idle it rests in green. A
// flash/fault mode blinks every lamp between red and off.
module traffic_phase_ctrl #(
    parameter int unsigned NUM_PHASES  = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned GREEN_TIME  = 5,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned FLASH_HALF  = 3,
    localparam int unsigned PH_W       = $clog2(NUM_PHASES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_PHASES-1:0]   phase_req,
    input  logic                    flash_mode,
    output logic [2*NUM_PHASES-1:0] light_colors,
    output logic [PH_W-1:0]         active_phase,
    output logic                    in_flash
);

    typedef enum logic [1:0] {
        S_GREEN,
        S_YELLOW,
        S_ALLRED,
        S_FLASH
    } state_t;

    localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] AR_LOAD = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] FH_LOAD = CNT_W'(FLASH_HALF - 1);

    localparam logic [1:0] LAMP_GREEN  = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_RED    = 2'b10;
    localparam logic [1:0] LAMP_OFF    = 2'b11;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        timer, timer_n;
    logic [PH_W-1:0]         phase_n;
    logic [PH_W-1:0]         next_phase;
    logic [NUM_PHASES-1:0]   demand, demand_n;
    logic                    flash_red, flash_red_n;
    logic                    timer_done;
    logic                    other_demand;
    logic [2*NUM_PHASES-1:0] lights_n;

    assign timer_done   = (timer == '0);
    assign other_demand = |(demand & ~(NUM_PHASES'(1) << active_phase));

    // Pick the first demanded phase after the active one, scanning cyclically;
    // with no demand at all, fall through to the immediate successor.
    always_comb begin
        logic [PH_W-1:0] cand;
        logic            found;
        cand       = '0;
        found      = 1'b0;
        next_phase = PH_W'((32'(active_phase) + 32'd1) % NUM_PHASES);
        for (int unsigned k = 1; k <= NUM_PHASES; k++) begin
            cand = PH_W'((32'(active_phase) + k) % NUM_PHASES);
            if (!found && demand[cand]) begin
                next_phase = cand;
                found      = 1'b1;
            end
        end
    end

    // Next-state, timer, demand-latch and lamp computation.
    always_comb begin
        state_n     = state;
        timer_n     = timer_done ? timer : timer - CNT_W'(1);
        phase_n     = active_phase;
        flash_red_n = flash_red;
        demand_n    = demand;

        // The phase currently showing green has already been served, so its
        // own request is ignored.
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            if (phase_req[i] && !(state == S_GREEN && active_phase == PH_W'(i)))
                demand_n[i] = 1'b1;
        end

        case (state)
            S_GREEN: begin
                if (flash_mode || (timer_done && other_demand)) begin
                    state_n = S_YELLOW;
                    timer_n = Y_LOAD;
                end
            end
            S_YELLOW: begin
                if (timer_done) begin
                    state_n = S_ALLRED;
                    timer_n = AR_LOAD;
                end
            end
            S_ALLRED: begin
                if (timer_done) begin
                    if (flash_mode) begin
                        state_n     = S_FLASH;
                        timer_n     = FH_LOAD;
                        flash_red_n = 1'b1;
                    end else begin
                        state_n              = S_GREEN;
                        timer_n              = G_LOAD;
                        phase_n              = next_phase;
                        // Clearing on green entry overrides a request arriving on the same edge.
                        demand_n[next_phase] = 1'b0;
                    end
                end
            end
            S_FLASH: begin
                if (!flash_mode) begin
                    state_n = S_ALLRED;
                    timer_n = AR_LOAD;
                end else if (timer_done) begin
                    flash_red_n = ~flash_red;
                    timer_n     = FH_LOAD;
                end
            end
            default: begin
                state_n = S_ALLRED;
                timer_n = AR_LOAD;
            end
        endcase

        // Lamps are derived from the next state so that they can be registered
        // alongside it, without a combinational path from the inputs.
        for (int unsigned i = 0; i < NUM_PHASES; i++) begin
            lights_n[2*i +: 2] = LAMP_RED;
            if (state_n == S_FLASH)
                lights_n[2*i +: 2] = flash_red_n ? LAMP_RED : LAMP_OFF;
            else if (phase_n == PH_W'(i) && state_n == S_GREEN)
                lights_n[2*i +: 2] = LAMP_GREEN;
            else if (phase_n == PH_W'(i) && state_n == S_YELLOW)
                lights_n[2*i +: 2] = LAMP_YELLOW;
        end
    end

    // State, timer, latches and registered outputs; enable low freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_ALLRED;
            timer        <= AR_LOAD;
            active_phase <= PH_W'(NUM_PHASES - 1);
            demand       <= '0;
            flash_red    <= 1'b1;
            light_colors <= {NUM_PHASES{LAMP_RED}};
            in_flash     <= 1'b0;
        end else if (enable) begin
            state        <= state_n;
            timer        <= timer_n;
            active_phase <= phase_n;
            demand       <= demand_n;
            flash_red    <= flash_red_n;
            light_colors <= lights_n;
            in_flash     <= (state_n == S_FLASH);
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Testbench for traffic_phase_ctrl: directed scenarios with literal
// expectations plus a cycle-by-cycle behavioural model and safety checks.
module tb_traffic_phase_ctrl;

    localparam int N  = 4;
    localparam int G  = 5;
    localparam int Y  = 2;
    localparam int AR = 1;
    localparam int FH = 3;

    localparam int M_G  = 0;
    localparam int M_Y  = 1;
    localparam int M_AR = 2;
    localparam int M_FL = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] phase_req;
    logic       flash_mode;
    logic [7:0] light_colors;
    logic [1:0] active_phase;
    logic       in_flash;

    int tests = 0;
    int fails = 0;

    traffic_phase_ctrl #(
        .NUM_PHASES (N),
        .CNT_W      (8),
        .GREEN_TIME (G),
        .YELLOW_TIME(Y),
        .ALLRED_TIME(AR),
        .FLASH_HALF (FH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .phase_req   (phase_req),
        .flash_mode  (flash_mode),
        .light_colors(light_colors),
        .active_phase(active_phase),
        .in_flash    (in_flash)
    );

    always #5 clk = ~clk;

    // Model: mode, cycles elapsed in that mode, owning phase, pending demand, flash lamp.
    typedef struct {
        int     mode;
        int     elapsed;
        int     act;
        bit [3:0] dem;
        bit     red;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.mode    = M_AR;
        r.elapsed = 0;
        r.act     = N - 1;
        r.dem     = '0;
        r.red     = 1'b1;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, bit [3:0] req, bit fl);
        model_t n = c;
        bit     other = 1'b0;
        int     pick;
        for (int j = 0; j < N; j++)
            if (c.dem[j] && j != c.act) other = 1'b1;
        for (int i = 0; i < N; i++)
            if (req[i] && !(c.mode == M_G && c.act == i)) n.dem[i] = 1'b1;
        n.elapsed = c.elapsed + 1;
        case (c.mode)
            M_G: if (fl || (c.elapsed >= G - 1 && other)) begin
                n.mode = M_Y; n.elapsed = 0;
            end
            M_Y: if (c.elapsed >= Y - 1) begin
                n.mode = M_AR; n.elapsed = 0;
            end
            M_AR: if (c.elapsed >= AR - 1) begin
                if (fl) begin
                    n.mode = M_FL; n.elapsed = 0; n.red = 1'b1;
                end else begin
                    pick = (c.act + 1) % N;
                    for (int k = N; k >= 1; k--)
                        if (c.dem[(c.act + k) % N]) pick = (c.act + k) % N;
                    n.mode = M_G; n.elapsed = 0; n.act = pick; n.dem[pick] = 1'b0;
                end
            end
            default: if (!fl) begin
                n.mode = M_AR; n.elapsed = 0;
            end else if (c.elapsed >= FH - 1) begin
                n.red = !c.red; n.elapsed = 0;
            end
        endcase
        return n;
    endfunction

    function automatic logic [7:0] model_lights(model_t c);
        logic [7:0] r;
        for (int i = 0; i < N; i++) begin
            r[2*i +: 2] = 2'b10;
            if (c.mode == M_FL)                  r[2*i +: 2] = c.red ? 2'b10 : 2'b11;
            else if (c.mode == M_G && c.act == i) r[2*i +: 2] = 2'b00;
            else if (c.mode == M_Y && c.act == i) r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    // At most one non-red phase, and per-phase order green -> yellow -> red.
    function automatic bit safety_ok(logic [7:0] cur, logic [7:0] prv, bit chk_order);
        int nonred = 0;
        bit ok = 1'b1;
        logic [1:0] c, p;
        for (int i = 0; i < N; i++) begin
            c = cur[2*i +: 2];
            p = prv[2*i +: 2];
            if (c == 2'b00 || c == 2'b01) nonred++;
            if (chk_order) begin
                if (c == 2'b01 && !(p == 2'b00 || p == 2'b01)) ok = 1'b0;
                if (c == 2'b00 && !(p == 2'b00 || p == 2'b10)) ok = 1'b0;
                if ((c == 2'b10 || c == 2'b11) && p == 2'b00) ok = 1'b0;
            end
        end
        return ok && (nonred <= 1);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model advances on the same events as the DUT.
    always @(posedge clk or posedge reset) begin
        if (reset)       m <= model_reset();
        else if (enable) m <= model_step(m, phase_req, flash_mode);
    end

    // Compare DUT against the model on every falling edge.
    logic [7:0] prev_lights;
    always @(negedge clk) begin
        chk("model.lights", light_colors, model_lights(m));
        chk("model.phase", active_phase, m.act);
        chk("model.flash", in_flash, (m.mode == M_FL));
        chk("safety", safety_ok(light_colors, prev_lights, !reset), 1);
        prev_lights <= light_colors;
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic lit(string nm, logic [7:0] l, logic [1:0] a, logic f);
        chk({nm, ".lights"}, light_colors, l);
        chk({nm, ".phase"}, active_phase, a);
        chk({nm, ".flash"}, in_flash, f);
    endtask

    task automatic wait_green(int ph, int budget);
        int k = 0;
        while (!(active_phase == ph && light_colors[2*ph +: 2] == 2'b00) && k < budget) begin
            step();
            k++;
        end
        chk($sformatf("reach_green_ph%0d", ph), (k < budget) ? 1 : 0, 1);
    endtask

    task automatic wait_flash(int budget);
        int k = 0;
        while (!in_flash && k < budget) begin
            step();
            k++;
        end
        chk("reach_flash", (k < budget) ? 1 : 0, 1);
    endtask

    initial begin
        logic [7:0] flash_seq [7];
        flash_seq = '{8'hAA, 8'hAA, 8'hAA, 8'hFF, 8'hFF, 8'hFF, 8'hAA};

        reset = 1'b1; enable = 1'b1; phase_req = '0; flash_mode = 1'b0;
        step(2);
        reset = 1'b0;
        lit("reset", 8'hAA, 2'd3, 1'b0);

        // Idle start: one all-red cycle, then phase 0 rests in green.
        step();     lit("first_green", 8'hA8, 2'd0, 1'b0);
        step(20);   lit("rest_green", 8'hA8, 2'd0, 1'b0);

        // Single request for phase 2: phase 1 is skipped.
        phase_req = 4'b0100; step(); phase_req = '0;
        lit("req2_latched", 8'hA8, 2'd0, 1'b0);
        step(); lit("ph0_yellow_a", 8'hA9, 2'd0, 1'b0);
        step(); lit("ph0_yellow_b", 8'hA9, 2'd0, 1'b0);
        step(); lit("allred", 8'hAA, 2'd0, 1'b0);
        step(); lit("ph2_green", 8'h8A, 2'd2, 1'b0);
        step(10);

        // Return to phase 0, then simultaneous requests 1 and 3.
        phase_req = 4'b0001; step(); phase_req = '0;
        wait_green(0, 20);
        phase_req = 4'b1010; step(); phase_req = '0;
        wait_green(1, 20); lit("ph1_green", 8'hA2, 2'd1, 1'b0);
        wait_green(3, 20); lit("ph3_green", 8'h2A, 2'd3, 1'b0);
        step(20);          lit("ph3_rests", 8'h2A, 2'd3, 1'b0);

        // Freeze mid-yellow; a request seen only while frozen is ignored.
        phase_req = 4'b0001; step(); phase_req = '0;
        step(); lit("ph3_yellow", 8'h6A, 2'd3, 1'b0);
        enable = 1'b0; phase_req = 4'b0010;
        step(); lit("frozen1", 8'h6A, 2'd3, 1'b0);
        step(); lit("frozen2", 8'h6A, 2'd3, 1'b0);
        phase_req = '0;
        step(); lit("frozen3", 8'h6A, 2'd3, 1'b0);
        enable = 1'b1;
        step(); lit("yellow_second", 8'h6A, 2'd3, 1'b0);
        step(); lit("allred2", 8'hAA, 2'd3, 1'b0);
        step(); lit("ph0_green2", 8'hA8, 2'd0, 1'b0);
        step(8); lit("ph0_rests", 8'hA8, 2'd0, 1'b0);

        // Flash requested in green cycle 2 of phase 1.
        phase_req = 4'b0010; step(); phase_req = '0;
        wait_green(1, 20);
        step(); flash_mode = 1'b1;
        step(); lit("fl_yellow_a", 8'hA6, 2'd1, 1'b0);
        step(); lit("fl_yellow_b", 8'hA6, 2'd1, 1'b0);
        step(); lit("fl_allred", 8'hAA, 2'd1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            lit($sformatf("flash_%0d", i), flash_seq[i], 2'd1, 1'b1);
        end
        flash_mode = 1'b0;
        step(); lit("flash_exit_allred", 8'hAA, 2'd1, 1'b0);
        step(); lit("after_flash_green", 8'h8A, 2'd2, 1'b0);

        // Async reset mid-green clears pending demand.
        phase_req = 4'b1000; step(); phase_req = '0;
        #2 reset = 1'b1;
        #1 lit("async_reset", 8'hAA, 2'd3, 1'b0);
        step(2); reset = 1'b0;
        step();   lit("post_reset_green", 8'hA8, 2'd0, 1'b0);
        step(10); lit("post_reset_rest", 8'hA8, 2'd0, 1'b0);

        // Async reset mid-flash.
        flash_mode = 1'b1;
        wait_flash(20);
        step(2);
        #2 reset = 1'b1;
        #1 lit("flash_reset", 8'hAA, 2'd3, 1'b0);
        flash_mode = 1'b0;
        step(2); reset = 1'b0;
        step(); lit("flash_reset_green", 8'hA8, 2'd0, 1'b0);
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
